// File: rtl/if_sequencer_pkg.sv
// Shared types for the IF-stage control sequencer: word type, FSM states,
// the bundled control-output struct and the default halt encoding.
package if_sequencer_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic  pc_stall;
        logic  branch_taken;
        logic  jump_taken;
        word_t branch_offset;
        word_t new_addr;
        logic  if_id_stall;
        logic  if_id_flush;
        logic  id_ex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Fetch frozen and IF/ID bubbled: used while draining and once halted.
    function automatic ctrl_t freeze_ctrl();
        ctrl_t c;
        c             = CTRL_IDLE;
        c.pc_stall    = 1'b1;
        c.if_id_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/if_sequencer_redirect_arbiter.sv
// Combinational priority encoder for redirect/stall requests:
// taken branch > load-use stall > jump > idle.
module redirect_arbiter (
    input  logic        load_use_hazard,
    input  logic        id_jump_req,
    input  logic [31:0] id_jump_target,
    input  logic        ex_branch_req,
    input  logic [31:0] ex_branch_offset,
    output logic        pc_stall,
    output logic        branch_taken,
    output logic        jump_taken,
    output logic [31:0] branch_offset,
    output logic [31:0] new_addr,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        active
);

    // NOTE: every output gets a default before the priority chain so no
    // path through the block leaves a signal unassigned (no latches).
    always_comb begin
        pc_stall      = 1'b0;
        branch_taken  = 1'b0;
        jump_taken    = 1'b0;
        branch_offset = '0;
        new_addr      = '0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        active        = 1'b1;
        if (ex_branch_req) begin
            // Younger jump/hazard sit on the wrong path and are squashed.
            branch_taken  = 1'b1;
            branch_offset = ex_branch_offset;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end else if (load_use_hazard) begin
            // The stalled instruction re-presents any jump next cycle.
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else if (id_jump_req) begin
            jump_taken  = 1'b1;
            new_addr    = id_jump_target;
            if_id_flush = 1'b1;
        end else begin
            active = 1'b0;
        end
    end

endmodule

// File: rtl/if_sequencer.sv
// IF-stage control sequencer: redirect arbitration, load-use stall and halt drain.
// Optional performance counters are built when IF_SEQ_PERF_EN is defined.
module if_sequencer
    import if_sequencer_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        load_use_hazard,
    input  logic        id_jump_req,
    input  logic [31:0] id_jump_target,
    input  logic        ex_branch_req,
    input  logic [31:0] ex_branch_offset,
    output logic        pc_stall,
    output logic        branch_taken,
    output logic        jump_taken,
    output logic [31:0] branch_offset,
    output logic [31:0] new_addr,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted
`ifdef IF_SEQ_PERF_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_flushes
`endif
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    seq_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    ctrl_t            arb_ctrl, ctrl;
    logic             arb_active;
    logic             arb_hazard;

    // A load-use hazard only matters in RUN; in DRAIN only redirects cancel.
    assign arb_hazard = load_use_hazard & (state == ST_RUN);

    redirect_arbiter u_arb (
        .load_use_hazard (arb_hazard),
        .id_jump_req     (id_jump_req),
        .id_jump_target  (id_jump_target),
        .ex_branch_req   (ex_branch_req),
        .ex_branch_offset(ex_branch_offset),
        .pc_stall        (arb_ctrl.pc_stall),
        .branch_taken    (arb_ctrl.branch_taken),
        .jump_taken      (arb_ctrl.jump_taken),
        .branch_offset   (arb_ctrl.branch_offset),
        .new_addr        (arb_ctrl.new_addr),
        .if_id_stall     (arb_ctrl.if_id_stall),
        .if_id_flush     (arb_ctrl.if_id_flush),
        .id_ex_flush     (arb_ctrl.id_ex_flush),
        .active          (arb_active)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ctrl       = CTRL_IDLE;
        unique case (state)
            ST_RUN: begin
                ctrl = arb_ctrl;
                if (!arb_active && instruction == HALT_WORD) begin
                    state_next = ST_DRAIN;
                    cnt_next   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (ex_branch_req || id_jump_req) begin
                    // The halt was fetched down a path now being abandoned.
                    ctrl       = arb_ctrl;
                    state_next = ST_RUN;
                end else begin
                    ctrl = freeze_ctrl();
                    if (cnt == '0) state_next = ST_HALTED;
                    else           cnt_next   = cnt - CNT_W'(1);
                end
            end
            ST_HALTED: ctrl = freeze_ctrl();
            default: state_next = ST_RUN;
        endcase
        if (rst) ctrl = CTRL_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign pc_stall      = ctrl.pc_stall;
    assign branch_taken  = ctrl.branch_taken;
    assign jump_taken    = ctrl.jump_taken;
    assign branch_offset = ctrl.branch_offset;
    assign new_addr      = ctrl.new_addr;
    assign if_id_stall   = ctrl.if_id_stall;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign halted        = (state == ST_HALTED) && !rst;

`ifdef IF_SEQ_PERF_EN
    logic [31:0] cycles_q, stalls_q, flushes_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q  <= '0;
            stalls_q  <= '0;
            flushes_q <= '0;
        end else begin
            if (state != ST_HALTED)                  cycles_q  <= cycles_q + 32'd1;
            if (state == ST_RUN && ctrl.pc_stall)    stalls_q  <= stalls_q + 32'd1;
            if (state == ST_RUN && ctrl.if_id_flush) flushes_q <= flushes_q + 32'd1;
        end
    end

    assign perf_cycles  = rst ? 32'd0 : cycles_q;
    assign perf_stalls  = rst ? 32'd0 : stalls_q;
    assign perf_flushes = rst ? 32'd0 : flushes_q;
`endif

endmodule
